// File: rtl/fan_pkg.sv
// Shared types for the fan speed sequencer: speed codes and the scheduler state encoding.
package fan_pkg;

    typedef logic [1:0] speed_t;

    localparam speed_t SPD_STOP = 2'd0;
    localparam speed_t SPD_SLOW = 2'd1;
    localparam speed_t SPD_MED  = 2'd2;
    localparam speed_t SPD_FAST = 2'd3;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        EVAL     = 3'd1,
        STEP     = 3'd2,
        WAIT_ACK = 3'd3,
        DWELL    = 3'd4
    } fan_state_e;

    // Neighbouring speed level in the requested direction (callers never step past 0 or 3).
    function automatic speed_t speed_step(input speed_t cur, input logic up);
        speed_t nxt;
        if (up) begin
            nxt = cur + 2'd1;
        end else begin
            nxt = cur - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/fan_pwm_gen.sv
// Free-running PWM generator: duty 0, 1/4, 1/2 or full according to the reported fan speed.
module fan_pwm_gen
    import fan_pkg::*;
#(
    parameter int PWM_W = 8
) (
    input  logic   clk,
    input  logic   reset_n,
    input  speed_t speed,
    output logic   pwm_out
);

    logic [PWM_W-1:0] cnt_r;
    logic [PWM_W-1:0] thresh_s;
    logic             pwm_s;

    // Duty compare: speed << (PWM_W-2) gives quarter-period steps; fast is held fully on.
    always_comb begin
        thresh_s = {speed, {(PWM_W-2){1'b0}}};
        if (speed == SPD_FAST) begin
            pwm_s = 1'b1;
        end else begin
            pwm_s = (cnt_r < thresh_s);
        end
    end

    // Period counter and registered PWM pin.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r   <= '0;
            pwm_out <= 1'b0;
        end else begin
            cnt_r   <= cnt_r + PWM_W'(1);
            pwm_out <= pwm_s;
        end
    end

endmodule

// File: rtl/fan_speed_sequencer.sv
// Closed-loop fan speed scheduler: temperature -> hysteretic target -> single-level steps with ack and dwell.
// Optional over-temperature override is built when FAN_SEQ_OVERTEMP_EN is defined.
module fan_speed_sequencer
    import fan_pkg::*;
#(
    parameter int TEMP_W      = 8,
    parameter int TH_SLOW     = 40,
    parameter int TH_MED      = 60,
    parameter int TH_FAST     = 80,
    parameter int HYST        = 4,
    parameter int DWELL_CYC   = 16,
    parameter int ACK_TIMEOUT = 4,
    parameter int PWM_W       = 8
`ifdef FAN_SEQ_OVERTEMP_EN
    ,
    parameter int TH_CRIT     = 100
`endif
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              temp_valid,
    input  logic [TEMP_W-1:0] temp,
    output logic              temp_ready,
    input  logic [1:0]        speed_in,
    output logic              fan_up,
    output logic              fan_down,
    output logic              busy,
    output logic              fault,
    output logic              pwm_out
`ifdef FAN_SEQ_OVERTEMP_EN
    ,
    output logic              overtemp
`endif
);

    localparam int CNT_MAX = (DWELL_CYC > ACK_TIMEOUT) ? DWELL_CYC : ACK_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [TEMP_W-1:0] UP_SLOW = TEMP_W'(TH_SLOW);
    localparam logic [TEMP_W-1:0] UP_MED  = TEMP_W'(TH_MED);
    localparam logic [TEMP_W-1:0] UP_FAST = TEMP_W'(TH_FAST);
    localparam logic [TEMP_W-1:0] DN_SLOW = TEMP_W'(TH_SLOW - HYST);
    localparam logic [TEMP_W-1:0] DN_MED  = TEMP_W'(TH_MED - HYST);
    localparam logic [TEMP_W-1:0] DN_FAST = TEMP_W'(TH_FAST - HYST);

    localparam logic [CNT_W-1:0] ACK_LAST   = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYC - 1);

    fan_state_e        state_r;
    logic [TEMP_W-1:0] temp_q_r;
    logic [CNT_W-1:0]  cnt_r;
    speed_t            expect_r;

    speed_t up_lvl_s;
    speed_t dn_lvl_s;
    speed_t norm_target_s;
    speed_t target_s;
    logic   accept_s;
    logic   force_fast_s;
    logic   skip_dwell_s;

    // Thresholds are strictly increasing, so the highest one crossed equals the count crossed.
    function automatic speed_t level_of(input logic [TEMP_W-1:0] t,
                                        input logic [TEMP_W-1:0] th_s,
                                        input logic [TEMP_W-1:0] th_m,
                                        input logic [TEMP_W-1:0] th_f);
        speed_t lvl;
        if (t >= th_f) begin
            lvl = SPD_FAST;
        end else if (t >= th_m) begin
            lvl = SPD_MED;
        end else if (t >= th_s) begin
            lvl = SPD_SLOW;
        end else begin
            lvl = SPD_STOP;
        end
        return lvl;
    endfunction

    assign accept_s = (state_r == IDLE) && temp_valid && temp_ready;

`ifdef FAN_SEQ_OVERTEMP_EN
    localparam logic [TEMP_W-1:0] CRIT_V = TEMP_W'(TH_CRIT);
    logic overtemp_r;

    // Over-temperature flag re-evaluated on every accepted sample.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overtemp_r <= 1'b0;
        end else if (accept_s) begin
            overtemp_r <= (temp >= CRIT_V);
        end else begin
            overtemp_r <= overtemp_r;
        end
    end

    assign overtemp     = overtemp_r;
    assign force_fast_s = overtemp_r;
    assign skip_dwell_s = overtemp_r;
`else
    assign force_fast_s = 1'b0;
    assign skip_dwell_s = 1'b0;
`endif

    // Target speed: rise immediately on the up thresholds, fall only below threshold minus hysteresis.
    always_comb begin
        up_lvl_s = level_of(temp_q_r, UP_SLOW, UP_MED, UP_FAST);
        dn_lvl_s = level_of(temp_q_r, DN_SLOW, DN_MED, DN_FAST);
        if (up_lvl_s > speed_in) begin
            norm_target_s = up_lvl_s;
        end else if (dn_lvl_s < speed_in) begin
            norm_target_s = dn_lvl_s;
        end else begin
            norm_target_s = speed_in;
        end
        if (force_fast_s) begin
            target_s = SPD_FAST;
        end else begin
            target_s = norm_target_s;
        end
    end

    // Scheduler FSM with registered handshake, step pulses and status.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= IDLE;
            temp_q_r   <= '0;
            cnt_r      <= '0;
            expect_r   <= SPD_STOP;
            fan_up     <= 1'b0;
            fan_down   <= 1'b0;
            busy       <= 1'b0;
            fault      <= 1'b0;
            temp_ready <= 1'b0;
        end else begin
            fan_up   <= 1'b0;
            fan_down <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        temp_q_r   <= temp;
                        state_r    <= EVAL;
                        busy       <= 1'b1;
                        temp_ready <= 1'b0;
                    end else begin
                        busy       <= 1'b0;
                        temp_ready <= 1'b1;
                    end
                end
                EVAL: begin
                    if (target_s == speed_in) begin
                        state_r    <= IDLE;
                        busy       <= 1'b0;
                        temp_ready <= 1'b1;
                    end else begin
                        state_r  <= STEP;
                        fan_up   <= (target_s > speed_in);
                        fan_down <= (target_s < speed_in);
                        expect_r <= speed_step(speed_in, target_s > speed_in);
                    end
                end
                STEP: begin
                    state_r <= WAIT_ACK;
                    cnt_r   <= '0;
                end
                WAIT_ACK: begin
                    // Speed changes other than the expected one are not acted upon here.
                    if (speed_in == expect_r) begin
                        cnt_r   <= '0;
                        state_r <= skip_dwell_s ? EVAL : DWELL;
                    end else if (cnt_r == ACK_LAST) begin
                        fault      <= 1'b1;
                        state_r    <= IDLE;
                        busy       <= 1'b0;
                        temp_ready <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                DWELL: begin
                    if (cnt_r == DWELL_LAST) begin
                        cnt_r   <= '0;
                        state_r <= EVAL;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    busy       <= 1'b0;
                    temp_ready <= 1'b1;
                end
            endcase
        end
    end

    fan_pwm_gen #(
        .PWM_W(PWM_W)
    ) u_pwm (
        .clk    (clk),
        .reset_n(reset_n),
        .speed  (speed_in),
        .pwm_out(pwm_out)
    );

endmodule

// File: tb/tb_fan_speed_sequencer.sv
// Scoreboard bench for fan_speed_sequencer: expected step pulses are queued by the stimulus and
// consumed by an independent pulse monitor; a small Moore fan-controller model answers the pulses.
module tb_fan_speed_sequencer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       temp_valid = 1'b0;
    logic [7:0] temp = 8'd0;
    logic [1:0] speed_in = 2'd0;
    logic       temp_ready, fan_up, fan_down, busy, fault, pwm_out;
`ifdef FAN_SEQ_OVERTEMP_EN
    logic       overtemp;
`endif

    always #5 clk = ~clk;

    fan_speed_sequencer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .temp_valid(temp_valid),
        .temp      (temp),
        .temp_ready(temp_ready),
        .speed_in  (speed_in),
        .fan_up    (fan_up),
        .fan_down  (fan_down),
        .busy      (busy),
        .fault     (fault),
        .pwm_out   (pwm_out)
`ifdef FAN_SEQ_OVERTEMP_EN
        ,
        .overtemp  (overtemp)
`endif
    );

    typedef struct {
        logic up;
        int   gap;
    } pulse_t;

    pulse_t exp_q[$];
    int     n_checks = 0;
    int     n_fail = 0;
    int     cyc = 0;
    int     last_pulse = 0;
    int     ready_busy_viol = 0;
    logic   ctrl_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0d, required %0d", name, act, req);
        end
    endtask

    function automatic pulse_t mk(input logic up, input int gap);
        pulse_t p;
        p.up  = up;
        p.gap = gap;
        return p;
    endfunction

    // Pulse monitor: every step pulse the DUT presents is popped against the scoreboard.
    always @(negedge clk) begin
        pulse_t p;
        cyc = cyc + 1;
        if (busy && temp_ready) ready_busy_viol = ready_busy_viol + 1;
        if (fan_up && fan_down) begin
            check("both_pulses", 32'd1, 32'd0);
        end else if (fan_up || fan_down) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {31'd0, fan_up}, 32'd2);
            end else begin
                p = exp_q.pop_front();
                check("pulse_dir_up", {31'd0, fan_up}, {31'd0, p.up});
                if (p.gap > 0) check("pulse_gap", cyc - last_pulse, p.gap);
            end
            last_pulse = cyc;
        end
    end

    // Moore fan controller model: a pulse seen in one cycle moves speed_in just after the next edge.
    initial begin : ctrl_model
        logic up_p, dn_p;
        forever begin
            @(negedge clk);
            up_p = ctrl_en && fan_up;
            dn_p = ctrl_en && fan_down;
            if (up_p || dn_p) begin
                @(posedge clk);
                #1;
                if (up_p) speed_in = speed_in + 2'd1;
                else      speed_in = speed_in - 2'd1;
            end
        end
    end

    task automatic send(input int t);
        int n;
        n = 0;
        @(negedge clk);
        temp = t[7:0];
        temp_valid = 1'b1;
        while (!temp_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!temp_ready) check("send_timeout", 32'd0, 32'd1);
        @(negedge clk);
        temp_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'd0, busy}, 32'd0);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int spd_tab[4];
        int duty_tab[4];
        int hi;
        spd_tab  = '{1, 2, 3, 0};
        duty_tab = '{64, 128, 256, 0};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_outputs", {26'd0, fan_up, fan_down, busy, fault, pwm_out, temp_ready}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", {31'd0, temp_ready}, 32'd1);
        check("busy_after_reset", {31'd0, busy}, 32'd0);

        // Two up steps from stop to med, with full dwell between them
        ctrl_en = 1'b1;
        speed_in = 2'd0;
        exp_q.push_back(mk(1'b1, 0));
        exp_q.push_back(mk(1'b1, 19));
        send(65);
        wait_idle("t1_idle", 200);
        check("t1_speed", {30'd0, speed_in}, 32'd2);
        check("t1_queue_empty", exp_q.size(), 32'd0);
        check("t1_fault", {31'd0, fault}, 32'd0);

        // Hysteresis: 57 holds med, 55 drops to slow
        @(negedge clk);
        speed_in = 2'd2;
        send(57);
        wait_idle("t2a_idle", 50);
        check("t2a_speed", {30'd0, speed_in}, 32'd2);
        exp_q.push_back(mk(1'b0, 0));
        send(55);
        wait_idle("t2b_idle", 100);
        check("t2b_speed", {30'd0, speed_in}, 32'd1);
        check("t2_queue_empty", exp_q.size(), 32'd0);

        // temp_valid held while busy: only the first sample is taken
        @(negedge clk);
        speed_in = 2'd0;
        ready_busy_viol = 0;
        exp_q.push_back(mk(1'b1, 0));
        send(45);
        temp_valid = 1'b1;
        temp = 8'd90;
        wait_idle("t4_idle", 100);
        temp_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("t4_ready_while_busy", ready_busy_viol, 32'd0);
        check("t4_speed", {30'd0, speed_in}, 32'd1);
        check("t4_queue_empty", exp_q.size(), 32'd0);

        // Ack timeout: controller does not respond
        ctrl_en = 1'b0;
        speed_in = 2'd0;
        exp_q.push_back(mk(1'b1, 0));
        send(45);
        @(negedge clk);
        check("t3_step_pulse", {31'd0, fan_up}, 32'd1);
        repeat (4) @(negedge clk);
        check("t3_fault_before_timeout", {31'd0, fault}, 32'd0);
        @(negedge clk);
        check("t3_fault_set", {31'd0, fault}, 32'd1);
        check("t3_idle", {31'd0, busy}, 32'd0);
        send(10);
        wait_idle("t3_idle2", 50);
        check("t3_fault_sticky", {31'd0, fault}, 32'd1);

        // Asynchronous reset in the middle of a dwell
        ctrl_en = 1'b1;
        speed_in = 2'd0;
        exp_q.push_back(mk(1'b1, 0));
        send(65);
        repeat (7) @(negedge clk);
        check("t5_in_dwell", {31'd0, busy}, 32'd1);
        check("t5_queue_empty", exp_q.size(), 32'd0);
        #2;
        reset_n = 1'b0;
        #1;
        check("t5_async_outputs", {26'd0, fan_up, fan_down, busy, fault, pwm_out, temp_ready}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("t5_ready", {31'd0, temp_ready}, 32'd1);
        check("t5_fault_cleared", {31'd0, fault}, 32'd0);
        repeat (25) @(negedge clk);
        check("t5_stays_idle", {31'd0, busy}, 32'd0);

        // PWM duty per speed level
        ctrl_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            speed_in = spd_tab[i][1:0];
            repeat (3) @(negedge clk);
            hi = 0;
            repeat (256) begin
                @(negedge clk);
                if (pwm_out) hi++;
            end
            check($sformatf("pwm_duty_spd%0d", spd_tab[i]), hi, duty_tab[i]);
        end

`ifdef FAN_SEQ_OVERTEMP_EN
        // Over-temperature: three back-to-back up steps without dwell, then release with dwell
        ctrl_en = 1'b1;
        speed_in = 2'd0;
        exp_q.push_back(mk(1'b1, 0));
        exp_q.push_back(mk(1'b1, 3));
        exp_q.push_back(mk(1'b1, 3));
        send(100);
        wait_idle("ot_idle", 100);
        check("ot_speed", {30'd0, speed_in}, 32'd3);
        check("ot_flag", {31'd0, overtemp}, 32'd1);
        check("ot_queue_empty", exp_q.size(), 32'd0);
        exp_q.push_back(mk(1'b0, 0));
        exp_q.push_back(mk(1'b0, 19));
        send(50);
        wait_idle("ot_release_idle", 200);
        check("ot_cleared", {31'd0, overtemp}, 32'd0);
        check("ot_release_speed", {30'd0, speed_in}, 32'd1);
`endif

        repeat (5) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
